// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the UART baud timebase: FSM state encoding,
// the default divisor width and the reset divisor computation.
package uart_baud_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    // Clock cycles per x16 tick for a given baud; truncating, never below 1.
    function automatic int calc_default_div(input int clk_freq_hz, input int baud);
        int div;
        div = clk_freq_hz / (16 * baud);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_tick_divider.sv
// Divisor counter plus 4-bit phase: produces the x16 oversampling strobe and
// the bit strobe that coincides with every 16th x16 strobe.
module uart_tick_divider
    import uart_baud_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 tick_x16,
    output logic                 tick_bit
);

    logic [DIV_WIDTH-1:0] count_reg;
    logic [3:0]           phase_reg;

    // The strobe fires on the last count of a period, so the first tick lands
    // exactly divisor cycles after the cycle in which counting was (re)started.
    assign tick_x16 = run && !clear && (count_reg == divisor - DIV_WIDTH'(1));
    assign tick_bit = tick_x16 && (phase_reg == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            phase_reg <= '0;
        end else if (clear || !run) begin
            count_reg <= '0;
            phase_reg <= '0;
        end else if (tick_x16) begin
            count_reg <= '0;
            phase_reg <= phase_reg + 4'd1;
        end else begin
            count_reg <= count_reg + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_baud_controller.sv
// UART baud timebase: owns the active divisor, accepts divisor changes over a
// valid/ready handshake and applies them only once both engines are idle.
module uart_baud_controller
    import uart_baud_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int DIV_WIDTH    = DIV_WIDTH_DEFAULT,
    parameter int DEFAULT_DIV  = calc_default_div(CLK_FREQ_HZ, DEFAULT_BAUD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_divisor,
    output logic                 cfg_ready,
    output logic                 cfg_error,
    output logic                 cfg_done,
    input  logic                 tx_busy,
    input  logic                 rx_busy,
    output logic                 tick_x16,
    output logic                 tick_bit,
    output logic [DIV_WIDTH-1:0] active_divisor,
    output logic [1:0]           state_o
);

    state_t               state_reg;
    state_t               state_next;
    logic [DIV_WIDTH-1:0] active_div_reg;
    logic [DIV_WIDTH-1:0] pending_div_reg;
    logic                 capture;
    logic                 load;
    logic                 run;
    logic                 clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_OFF;
            active_div_reg  <= DIV_WIDTH'(DEFAULT_DIV);
            pending_div_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                pending_div_reg <= cfg_divisor;
            end
            if (load) begin
                active_div_reg <= pending_div_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cfg_ready  = 1'b0;
        cfg_error  = 1'b0;
        cfg_done   = 1'b0;
        capture    = 1'b0;
        load       = 1'b0;
        case (state_reg)
            ST_OFF: begin
                if (cfg_valid) begin
                    cfg_ready = 1'b1;
                    if (cfg_divisor == '0) begin
                        cfg_error = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        state_next = ST_LOAD;
                    end
                end else if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // An accepted request always goes through DRAIN so it is never
                // lost; DRAIN itself exits at once when enable is low.
                if (cfg_valid && cfg_divisor != '0) begin
                    cfg_ready  = 1'b1;
                    capture    = 1'b1;
                    state_next = ST_DRAIN;
                end else begin
                    if (cfg_valid) begin
                        cfg_ready = 1'b1;
                        cfg_error = 1'b1;
                    end
                    if (!enable) begin
                        state_next = ST_OFF;
                    end
                end
            end
            ST_DRAIN: begin
                if ((!tx_busy && !rx_busy) || !enable) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load       = 1'b1;
                cfg_done   = 1'b1;
                state_next = enable ? ST_RUN : ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
    end

    assign run   = enable && (state_reg == ST_RUN || state_reg == ST_DRAIN);
    assign clear = (state_reg == ST_LOAD);

    uart_tick_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clear    (clear),
        .divisor  (active_div_reg),
        .tick_x16 (tick_x16),
        .tick_bit (tick_bit)
    );

    assign active_divisor = active_div_reg;
    assign state_o        = state_reg;

endmodule
